// File: rtl/rs_msg_deframer.sv
// rs_msg_deframer: realigns decoded RS symbols to frame timing, strips parity,
// and delivers message symbols with sop/eop via a FWFT valid/ready FIFO.
// Optional frame counter enabled by defining RS_DEFRAME_FCNT_EN.
module rs_msg_deframer #(
  parameter int N          = 255,
  parameter int K          = 239,
  parameter int M          = 8,
  parameter int LATENCY    = 287,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         sync,
  input  logic [M-1:0] data_in,
  output logic [M-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_sop,
  output logic         m_eop,
  output logic         overflow,
  output logic [15:0]  frame_cnt
);

  localparam int IW = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = M + 2;

  typedef enum logic [1:0] {
    IDLE,
    MSG,
    PARITY
  } state_t;

  logic [LATENCY-1:0] r_sync_sr;
  logic               w_sync_d;
  logic [IW-1:0]      r_idx;
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_wr;
  logic [EW-1:0]      w_wr_entry;

  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [EW-1:0]      r_mem [FIFO_DEPTH];
  logic [EW-1:0]      w_head;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               r_overflow;

  assign w_sync_d = r_sync_sr[LATENCY-1];

  // Sync delay line: matches the decoder latency so sync_d lines up with data_in.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync_sr <= '1;
    end else begin
      r_sync_sr[0] <= sync;
      for (int i = 1; i < LATENCY; i++) begin
        r_sync_sr[i] <= r_sync_sr[i-1];
      end
    end
  end

  // Symbol index within the frame; wraps so back-to-back frames need no gap.
  always_ff @(posedge clk_in) begin
    if (rst || w_sync_d) begin
      r_idx <= '0;
    end else if (r_idx == IW'(N-1)) begin
      r_idx <= '0;
    end else begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and write strobe; IDLE means the next live symbol is index 0.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    if (w_sync_d) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE, MSG: begin
          w_wr        = 1'b1;
          w_state_nxt = (r_idx == IW'(K-1)) ? PARITY : MSG;
        end
        PARITY: begin
          w_state_nxt = (r_idx == IW'(N-1)) ? MSG : PARITY;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign w_wr_entry = {(r_idx == '0), (r_idx == IW'(K-1)), data_in};

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && m_ready;
  assign w_push  = w_wr && (!w_full || w_pop);
  assign w_drop  = w_wr && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign m_valid = !w_empty;
  assign {m_sop, m_eop, m_data} = w_empty ? '0 : w_head;
  assign overflow = r_overflow;

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef RS_DEFRAME_FCNT_EN
  logic [15:0] r_frame_cnt;

  // Count frames whose eop symbol actually entered the FIFO.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_push && w_wr_entry[M]) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule
